// File: rtl/uart_master_pkg.sv
// uart_master_pkg: UART register map, status bit positions
// and the service FSM states shared by uart_dsp_master.
package uart_master_pkg;

    localparam logic [3:0] REG_DR   = 4'd0;
    localparam logic [3:0] REG_LCR  = 4'd1;
    localparam logic [3:0] REG_FCR  = 4'd2;
    localparam logic [3:0] REG_CR   = 4'd3;
    localparam logic [3:0] REG_FR   = 4'd4;
    localparam logic [3:0] REG_IER  = 4'd5;
    localparam logic [3:0] REG_ISR  = 4'd6;
    localparam logic [3:0] REG_IBRD = 4'd7;

    localparam int FR_TXFF = 7;
    localparam int FR_RXFE = 4;
    localparam int ISR_TX  = 3;
    localparam int ISR_RX  = 2;
    localparam int ISR_RT  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        ISR_RD = 3'd2,
        ICR_WR = 3'd3,
        TX_FR  = 3'd4,
        TX_WR  = 3'd5,
        RX_DR  = 3'd6,
        RX_FR  = 3'd7
    } state_e;

    // Init writes go IBRD, LCR, FCR, IER, then CR last to enable.
    function automatic logic [3:0] init_addr(input logic [2:0] idx);
        logic [3:0] a;
        unique case (idx)
            3'd0:    a = REG_IBRD;
            3'd1:    a = REG_LCR;
            3'd2:    a = REG_FCR;
            3'd3:    a = REG_IER;
            default: a = REG_CR;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/uart_master_fifo.sv
// uart_master_fifo: synchronous FIFO, first-word fall-through.
// Push when full and pop when empty are refused independently.
module uart_master_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage is unreset; the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_dsp_master.sv
// uart_dsp_master: drives a UART over the DSP async bus, running init,
// interrupt service and TX/RX byte queues. Option: UART_MASTER_POLL_EN.
module uart_dsp_master
    import uart_master_pkg::*;
#(
    parameter int TXQ_DEPTH   = 8,
    parameter int RXQ_DEPTH   = 8,
    parameter int MAX_BURST   = 16,
    parameter int POLL_PERIOD = 1024
) (
    input  logic        DSP0_CLK,
    input  logic        RESETn,
    input  logic        start,
    input  logic [15:0] cfg_ibrd,
    input  logic [15:0] cfg_lcr,
    input  logic [15:0] cfg_fcr,
    input  logic [15:0] cfg_ier,
    input  logic [15:0] cfg_cr,
    output logic        DSP_CEn,
    output logic        DSP_WEn,
    output logic [3:0]  DSP_ADDR,
    output logic [15:0] DSP_WDATA,
    input  logic [15:0] DSP_RDATA,
    input  logic        IRQn,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        busy,
    output logic        rx_overflow,
    input  logic        rx_ovf_clr
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    state_e        state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    isr_q, isr_d;
    logic [7:0]    rd_q, rd_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          irq_s_q, irq_d_q, irq_edge;
    logic          svc, poll_hit;
    logic          tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic          rx_push, rx_full, rx_empty;
    logic          rd_end, wr_end;
    logic          unused_rdata;

    assign unused_rdata = ^DSP_RDATA[15:8];
    assign irq_edge     = irq_d_q & ~irq_s_q;
    // Reads: strobe, gap (data captured at its end), decide.
    assign rd_end       = (ph_q == 2'd2);
    // Writes: strobe, gap (decide at its end).
    assign wr_end       = (ph_q == 2'd1);

    uart_master_fifo #(.DW(8), .DEPTH(TXQ_DEPTH)) u_txq (
        .clk_i  (DSP0_CLK),
        .rst_ni (RESETn),
        .push_i (tx_valid),
        .wdata_i(tx_data),
        .pop_i  (tx_pop),
        .rdata_o(tx_head),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    uart_master_fifo #(.DW(8), .DEPTH(RXQ_DEPTH)) u_rxq (
        .clk_i  (DSP0_CLK),
        .rst_ni (RESETn),
        .push_i (rx_push),
        .wdata_i(rd_q),
        .pop_i  (rx_ready),
        .rdata_o(rx_data),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    assign tx_ready    = !tx_full;
    assign rx_valid    = !rx_empty;
    assign init_done   = done_q;
    assign busy        = (state_q != IDLE);
    assign rx_overflow = ovf_q;

`ifdef UART_MASTER_POLL_EN
    localparam int PW = $clog2(POLL_PERIOD + 1);
    logic [PW-1:0] poll_q;
    logic          poll_arm;

    assign poll_arm = (state_q == IDLE) && done_q && !tx_empty;
    assign poll_hit = poll_arm && (poll_q == PW'(POLL_PERIOD - 1));

    // Idle poll timer; any interrupt service restarts the interval.
    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn)       poll_q <= '0;
        else if (svc)      poll_q <= '0;
        else if (poll_hit) poll_q <= '0;
        else if (poll_arm) poll_q <= poll_q + PW'(1);
    end
`else
    localparam int unused_poll = POLL_PERIOD;
    assign poll_hit = 1'b0;
`endif

    // Service sequencer: next state, bus phase and status flags.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + 2'd1;
        idx_d   = idx_q;
        isr_d   = isr_q;
        rd_d    = rd_q;
        burst_d = burst_q;
        pend_d  = pend_q;
        done_d  = done_q;
        ovf_d   = ovf_q & ~rx_ovf_clr;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        svc     = 1'b0;
        if (irq_edge && done_q && state_q != IDLE) pend_d = 1'b1;
        if (ph_q == 2'd1) rd_d = DSP_RDATA[7:0];
        unique case (state_q)
            IDLE: begin
                ph_d = 2'd0;
                if (start && !done_q) begin
                    state_d = INIT;
                    idx_d   = 3'd0;
                end else if (done_q && (irq_edge || pend_q)) begin
                    state_d = ISR_RD;
                    pend_d  = 1'b0;
                    svc     = 1'b1;
                end else if (poll_hit) begin
                    state_d = TX_FR;
                    burst_d = '0;
                end
            end
            INIT: begin
                ph_d  = 2'd0;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd4) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ISR_RD: if (rd_end) begin
                ph_d    = 2'd0;
                isr_d   = rd_q[3:0];
                state_d = ICR_WR;
            end
            ICR_WR: if (wr_end) begin
                ph_d    = 2'd0;
                burst_d = '0;
                if (isr_q[ISR_RX] || isr_q[ISR_RT]) state_d = RX_DR;
                else if (isr_q[ISR_TX])             state_d = TX_FR;
                else                                state_d = IDLE;
            end
            TX_FR: if (rd_end) begin
                ph_d = 2'd0;
                if (!rd_q[FR_TXFF] && !tx_empty && burst_q < BURST_MAX)
                    state_d = TX_WR;
                else
                    state_d = IDLE;
            end
            TX_WR: if (wr_end) begin
                ph_d    = 2'd0;
                tx_pop  = 1'b1;
                burst_d = burst_q + BW'(1);
                state_d = TX_FR;
            end
            RX_DR: if (rd_end) begin
                ph_d    = 2'd0;
                state_d = RX_FR;
                if (rx_full) ovf_d   = 1'b1;
                else         rx_push = 1'b1;
            end
            RX_FR: if (rd_end) begin
                ph_d = 2'd0;
                if (!rd_q[FR_RXFE])      state_d = RX_DR;
                else if (isr_q[ISR_TX])  state_d = TX_FR;
                else                     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and IRQn edge-detect registers.
    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            ph_q    <= 2'd0;
            idx_q   <= 3'd0;
            isr_q   <= 4'd0;
            rd_q    <= 8'd0;
            burst_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            irq_s_q <= 1'b1;
            irq_d_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            isr_q   <= isr_d;
            rd_q    <= rd_d;
            burst_q <= burst_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            irq_s_q <= IRQn;
            irq_d_q <= irq_s_q;
        end
    end

    // Bus pins decoded from state so reset parks them at once.
    always_comb begin
        DSP_CEn   = 1'b1;
        DSP_WEn   = 1'b1;
        DSP_ADDR  = REG_DR;
        DSP_WDATA = 16'h0000;
        unique case (state_q)
            INIT: begin
                DSP_CEn  = 1'b0;
                DSP_WEn  = 1'b0;
                DSP_ADDR = init_addr(idx_q);
                unique case (idx_q)
                    3'd0:    DSP_WDATA = cfg_ibrd;
                    3'd1:    DSP_WDATA = cfg_lcr;
                    3'd2:    DSP_WDATA = cfg_fcr;
                    3'd3:    DSP_WDATA = cfg_ier;
                    default: DSP_WDATA = cfg_cr;
                endcase
            end
            ISR_RD: begin
                DSP_CEn  = (ph_q != 2'd0);
                DSP_ADDR = REG_ISR;
            end
            ICR_WR: begin
                DSP_CEn   = (ph_q != 2'd0);
                DSP_WEn   = (ph_q != 2'd0);
                DSP_ADDR  = REG_ISR;
                DSP_WDATA = {12'h000, isr_q};
            end
            TX_FR, RX_FR: begin
                DSP_CEn  = (ph_q != 2'd0);
                DSP_ADDR = REG_FR;
            end
            TX_WR: begin
                DSP_CEn   = (ph_q != 2'd0);
                DSP_WEn   = (ph_q != 2'd0);
                DSP_WDATA = {8'h00, tx_head};
            end
            RX_DR: DSP_CEn = (ph_q != 2'd0);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_dsp_master.sv
// tb_uart_dsp_master: randomized scoreboard bench with a UART slave
// model; expected bus writes and RX bytes come from queue-level models.
module tb_uart_dsp_master;

  localparam int TXQ  = 32;
  localparam int RXQ  = 8;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_ibrd = 16'h0008;
  logic [15:0] cfg_lcr = 16'h003D;
  logic [15:0] cfg_fcr = 16'h00CC;
  logic [15:0] cfg_ier = 16'h000F;
  logic [15:0] cfg_cr = 16'h0007;
  logic        DSP_CEn, DSP_WEn;
  logic [3:0]  DSP_ADDR;
  logic [15:0] DSP_WDATA;
  logic [15:0] DSP_RDATA = 16'h0000;
  logic        IRQn = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        init_done, busy, rx_overflow;
  logic        rx_ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_w[$];
  logic [7:0]  tx_model[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  rx_src[$];
  logic [3:0]  isr_val = 4'h0;
  int          txff_after = 1000;
  int          dr_wr_cnt = 0;
  logic        ovf_exp = 1'b0;
  logic [15:0] fr;

  uart_dsp_master #(
    .TXQ_DEPTH(TXQ), .RXQ_DEPTH(RXQ),
    .MAX_BURST(MAXB), .POLL_PERIOD(1024)
  ) dut (
    .DSP0_CLK(clk), .RESETn(rst_n), .start(start),
    .cfg_ibrd(cfg_ibrd), .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr),
    .cfg_ier(cfg_ier), .cfg_cr(cfg_cr),
    .DSP_CEn(DSP_CEn), .DSP_WEn(DSP_WEn), .DSP_ADDR(DSP_ADDR),
    .DSP_WDATA(DSP_WDATA), .DSP_RDATA(DSP_RDATA), .IRQn(IRQn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .init_done(init_done), .busy(busy), .rx_overflow(rx_overflow),
    .rx_ovf_clr(rx_ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor, UART slave responder and RX pop checker.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!DSP_CEn && !DSP_WEn) begin
        if (exp_w.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h, none expected",
                   DSP_ADDR, DSP_WDATA);
        end else begin
          chk("bus_write", {DSP_ADDR, DSP_WDATA}, exp_w.pop_front());
        end
        if (DSP_ADDR == 4'd0) dr_wr_cnt++;
      end
      if (!DSP_CEn && DSP_WEn) begin
        case (DSP_ADDR)
          4'd6: begin
            DSP_RDATA = {12'hA5A, isr_val};
            dr_wr_cnt = 0;
          end
          4'd4: begin
            fr = 16'h0000;
            fr[7] = (dr_wr_cnt >= txff_after);
            fr[4] = (rx_src.size() == 0);
            DSP_RDATA = fr;
          end
          4'd0: begin
            if (rx_src.size() != 0) DSP_RDATA = {8'hC3, rx_src.pop_front()};
            else DSP_RDATA = 16'h0000;
          end
          default: DSP_RDATA = 16'h0000;
        endcase
      end
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx: got %0h, none expected", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_rx.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_cen"}, DSP_CEn, 1);
    chk({tag, "_wen"}, DSP_WEn, 1);
    chk({tag, "_addr"}, DSP_ADDR, 0);
    chk({tag, "_wdata"}, DSP_WDATA, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, rx_overflow, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 200) begin
      tick(1);
      t++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data = b;
    tick(1);
    tx_valid = 1'b0;
    tx_model.push_back(b);
  endtask

  task automatic add_rx(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      rx_src.push_back(b);
      if (exp_rx.size() < RXQ) exp_rx.push_back(b);
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic expect_service(input logic [3:0] isr, input int txff);
    int n;
    exp_w.push_back({4'd6, 12'h000, isr});
    if (isr[3]) begin
      n = tx_model.size();
      if (n > MAXB) n = MAXB;
      if (n > txff) n = txff;
      repeat (n) exp_w.push_back({4'd0, 8'h00, tx_model.pop_front()});
    end
  endtask

  task automatic fire_irq();
    IRQn = 1'b0;
    tick(3);
    IRQn = 1'b1;
    tick(1);
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int t = 0;
    tick(4);
    while (quiet < 4 && t < 3000) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      t++;
    end
    chk({name, "_idle"}, (quiet >= 4), 1);
    chk({name, "_drained"}, exp_w.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx_empty(input string name);
    int t = 0;
    while (rx_valid && t < 200) begin
      tick(1);
      t++;
    end
    chk({name, "_rx_valid"}, rx_valid, 0);
    chk({name, "_rx_drained"}, exp_rx.size(), 0);
  endtask

  task automatic do_init();
    exp_w.push_back({4'd7, cfg_ibrd});
    exp_w.push_back({4'd1, cfg_lcr});
    exp_w.push_back({4'd2, cfg_fcr});
    exp_w.push_back({4'd5, cfg_ier});
    exp_w.push_back({4'd3, cfg_cr});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("init_cen_low", DSP_CEn, 0);
      chk("init_not_done", init_done, 0);
    end
    @(negedge clk);
    chk("init_done_set", init_done, 1);
    chk("init_cen_high", DSP_CEn, 1);
    chk("init_drained", exp_w.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic found;
    int ntx;
    logic [3:0] isr;

    #2 rst_n = 1'b0;
    #20;
    check_reset_outs("reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    do_init();

    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    chk("start_ignored_busy", busy, 0);

    for (int i = 1; i <= 20; i++) push_tx(8'(i));
    isr_val = 4'h8;
    txff_after = 1000;
    expect_service(4'h8, txff_after);
    fire_irq();
    wait_idle("tx_burst");

    for (int i = 0; i < 5; i++) push_tx(8'($urandom));
    txff_after = 3;
    expect_service(4'h8, txff_after);
    fire_irq();
    wait_idle("tx_full_stop");
    chk("tx_full_stop_busy", busy, 0);

    for (int i = 0; i < 14; i++) push_tx(8'($urandom));
    txff_after = 1000;
    expect_service(4'h8, txff_after);
    expect_service(4'h8, txff_after);
    fire_irq();
    t = 0;
    while (dr_wr_cnt < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("pend_busy", busy, 1);
    fire_irq();
    wait_idle("pending");

    isr_val = 4'h4;
    add_rx(10);
    expect_service(4'h4, txff_after);
    fire_irq();
    wait_idle("rx_ovf");
    chk("rx_ovf_set", rx_overflow, ovf_exp);
    chk("rx_ovf_valid", rx_valid, 1);
    rx_ready = 1'b1;
    wait_rx_empty("rx_ovf");
    rx_ovf_clr = 1'b1;
    tick(1);
    rx_ovf_clr = 1'b0;
    ovf_exp = 1'b0;
    chk("rx_ovf_clear", rx_overflow, ovf_exp);

    for (int it = 0; it < 8; it++) begin
      ntx = $urandom_range(0, 6);
      case ($urandom_range(0, 4))
        0: isr = 4'h8;
        1: isr = 4'h4;
        2: isr = 4'h2;
        3: isr = 4'hC;
        default: isr = 4'hA;
      endcase
      for (int k = 0; k < ntx; k++) push_tx(8'($urandom));
      isr_val = isr;
      txff_after = $urandom_range(1, 8);
      if (isr[2] || isr[1]) add_rx($urandom_range(1, 5));
      expect_service(isr, txff_after);
      fire_irq();
      wait_idle("rand");
      wait_rx_empty("rand");
    end
    chk("rand_no_ovf", rx_overflow, 0);

    for (int i = 0; i < 4; i++) push_tx(8'($urandom));
    isr_val = 4'h8;
    txff_after = 1000;
    expect_service(4'h8, txff_after);
    fire_irq();
    found = 1'b0;
    t = 0;
    while (!found && t < 300) begin
      @(negedge clk);
      if (!DSP_CEn && !DSP_WEn && DSP_ADDR == 4'd0) found = 1'b1;
      t++;
    end
    chk("rst_mid_found_dr_write", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    exp_w.delete();
    tx_model.delete();
    exp_rx.delete();
    rx_src.delete();
    dr_wr_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("rst_mid_quiet_busy", busy, 0);
    do_init();
    expect_service(4'h8, txff_after);
    fire_irq();
    wait_idle("rst_mid_txq_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
